neuron_mac_seq: RTL and testbench
=================================

// Module: neuron_mac_seq
// PURPOSE
//  Parametrised, time-multiplexed fixed-point neuron for the RNN accelerator datapath.
//  - Holds N_IN signed weights in an internal register file.
//  - Accepts N_IN input samples serially over a valid/ready stream and accumulates x[i]*w[i].
//  - Adds the bias and emits one rounded, saturated result per input vector.
//  - One multiplier in place of N_IN; a layer instantiates one per output unit.
// PARAMETERS
//  N_IN    8   inputs per vector (>=2); also the weight-file depth
//  DATA_W  32  signed width of x, w, b, y
//  FRAC_W  16  fraction bits (Q(DATA_W-FRAC_W).FRAC_W); 0 < FRAC_W < DATA_W
// PORTS
//  clk      in   1                  clock, rising edge
//  rst      in   1                  asynchronous, active-high reset
//  w_we     in   1                  weight write strobe
//  w_addr   in   $clog2(N_IN)       weight index
//  w_data   in   DATA_W             weight value, signed
//  b        in   DATA_W             bias, signed; sampled on the last accepted beat
//  x_valid  in   1                  input sample valid
//  x_ready  out  1                  block can accept a sample
//  x_data   in   DATA_W             input sample, signed
//  y_valid  out  1                  result valid
//  y_ready  in   1                  downstream accepts the result
//  y_data   out  DATA_W             neuron output, signed
//  y_sat    out  1                  y_data was saturated; qualified by y_valid
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE, idx=0, acc=0, x_ready=0, y_valid=0, y_data=0, y_sat=0,
//    all weights=0. x_ready rises on the first clk edge after rst deasserts.
//  - FSM states:
//    IDLE: x_ready=1. An accepted beat (x_valid&x_ready) moves to ACC with idx=1.
//    ACC:  x_ready=1. Each accepted beat adds x*w[idx] and increments idx.
//          The beat at idx==N_IN-1 completes the vector and moves to OUT.
//    OUT:  x_ready=0, y_valid=1. y_data and y_sat are held stable until y_ready.
//          y_valid&y_ready returns to IDLE, clears acc and idx, and drops y_valid next cycle.
//  - Stalls: gaps in x_valid are allowed in any state; acc and idx hold.
//  - Latency: y_valid is asserted the cycle after the last beat is accepted.
//    Minimum throughput is one vector per N_IN+1 cycles.
//  - Arithmetic:
//    - product = signed x*w, 2*DATA_W bits.
//    - acc = signed, 2*DATA_W+$clog2(N_IN) bits, so it never overflows internally.
//    - final = (acc + (b <<< FRAC_W) + 2**(FRAC_W-1)) >>> FRAC_W; arithmetic shift, round half up.
//    - If final is outside the DATA_W signed range, y_data = +max or -min and y_sat=1.
//  - Weights:
//    - A write takes effect the next cycle. A read of the same index in the write cycle returns
//      the old value.
//    - Writes are accepted in every state.
//    - w_addr >= N_IN: the write is ignored.
//  - Mid-operation reset: the partial vector is discarded, no output is produced, and weights
//    return to 0.
// CONFIGURATION
//  RELU_EN:
//    - Defined: the saturated result is passed through ReLU; negative values give y_data=0.
//      y_sat still reports negative saturation.
//    - Undefined: y_data is the signed saturated value (identity activation).
// TESTING
//  1. Load w[i]=1.0 (0x00010000); send x=1..8 as 0x00010000..0x00080000 with b=0
//     -> y_data=0x00240000 (36.0), y_sat=0, y_valid one cycle after beat 8.
//  2. As test 1 with b=0xFFFF0000 (-1.0) -> y_data=0x00230000.
//  3. w[i]=0x7FFFFFFF, x[i]=0x7FFFFFFF for all i
//     -> y_data=0x7FFFFFFF, y_sat=1. All w negated -> y_data=0x80000000, y_sat=1.
//  4. Hold y_ready=0 for 5 cycles in OUT -> x_ready=0 and y_data stable throughout.
//     Then y_ready=1 -> IDLE; the next vector is accepted on the following cycle.
//  5. Assert rst after beat 4 -> all outputs 0 immediately. A fresh vector of test 1
//     (weights reloaded) -> 0x00240000.
//  6. RELU_EN defined, w=1.0, x=-1.0 for all i, b=0 -> y_data=0, y_sat=0.
//     Undefined -> 0xFFF80000.

Source files
------------

// File: rtl/neuron_mac_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// neuron_mac_seq
//   Time-multiplexed fixed-point neuron. N_IN signed weights sit in a local
//   register file; the input vector arrives one sample per accepted beat and
//   is accumulated with a single multiplier. On the last beat the bias is
//   added, the sum is rounded (half up) back to Q(DATA_W-FRAC_W).FRAC_W,
//   saturated to DATA_W bits and presented on the output stream.
//
//   Optional feature macro: RELU_EN
//     defined   -> saturated result passes through ReLU (negatives give 0,
//                  y_sat still flags negative saturation)
//     undefined -> identity activation
//
//   Handshake: a beat transfers on a rising clk edge where valid and ready
//   are both high. The producer holds data stable while valid is high and
//   ready is low; the receiver may change ready at any time.
//
//   Ports
//     clk, rst          clock (rising edge), async active-high reset
//     w_we/w_addr/w_data weight write port; out-of-range addresses ignored
//     b                 bias, sampled on the last accepted input beat
//     x_valid/x_ready/x_data  input sample stream
//     y_valid/y_ready/y_data  result stream
//     y_sat             result was clipped; qualified by y_valid
//
//   Internal FSM state is held in `state` (type state_t) for probing.
// ---------------------------------------------------------------------------
module neuron_mac_seq #(
   parameter int N_IN   = 8,
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    w_we,
   input  logic [$clog2(N_IN)-1:0] w_addr,
   input  logic [DATA_W-1:0]       w_data,
   input  logic [DATA_W-1:0]       b,
   input  logic                    x_valid,
   output logic                    x_ready,
   input  logic [DATA_W-1:0]       x_data,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic [DATA_W-1:0]       y_data,
   output logic                    y_sat
);

   localparam int IDX_W  = $clog2(N_IN);
   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = PROD_W + IDX_W;
   // One extra bit so acc + shifted bias + rounding constant cannot wrap.
   localparam int SUM_W  = ACC_W + 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

   localparam logic signed [SUM_W-1:0] ROUND =
      {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
   localparam logic signed [SUM_W-1:0] Y_MAX =
      {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] Y_MIN =
      {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [DATA_W-1:0]        w_mem [N_IN];
   logic [IDX_W-1:0]         idx;
   logic signed [ACC_W-1:0]  acc;

   logic                     accept;
   logic                     last_beat;
   logic                     y_take;
   logic                     x_ready_next;
   logic                     y_valid_next;

   logic [DATA_W-1:0]        w_rd;
   logic signed [PROD_W-1:0] x_ext;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] product;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [SUM_W-1:0]  acc_wide;
   logic signed [SUM_W-1:0]  bias_wide;
   logic signed [SUM_W-1:0]  bias_sh;
   logic signed [SUM_W-1:0]  sum;
   logic signed [SUM_W-1:0]  shifted;
   logic                     sat_hi;
   logic                     sat_lo;
   logic [DATA_W-1:0]        y_clip;
   logic [DATA_W-1:0]        y_act;

   // ------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------
   assign accept    = x_valid & x_ready;
   assign last_beat = (idx == LAST_IDX);
   assign y_take    = y_valid & y_ready;

   // ------------------------------------------------------------------
   // Datapath: one multiply per beat, full-precision accumulation
   // ------------------------------------------------------------------
   // Weight read is from the register array, so a write in this cycle is
   // not yet visible: the old value is used.
   assign w_rd     = w_mem[idx];
   assign x_ext    = {{DATA_W{x_data[DATA_W-1]}}, x_data};
   assign w_ext    = {{DATA_W{w_rd[DATA_W-1]}}, w_rd};
   assign product  = x_ext * w_ext;
   assign prod_ext = {{IDX_W{product[PROD_W-1]}}, product};
   assign acc_next = acc + prod_ext;

   // Bias is Q.FRAC_W; the accumulator is Q.(2*FRAC_W), so align the bias
   // before adding, then round half up and drop FRAC_W fraction bits.
   assign acc_wide  = {acc_next[ACC_W-1], acc_next};
   assign bias_wide = {{(SUM_W-DATA_W){b[DATA_W-1]}}, b};
   assign bias_sh   = bias_wide <<< FRAC_W;
   assign sum       = acc_wide + bias_sh + ROUND;
   assign shifted   = sum >>> FRAC_W;

   assign sat_hi = (shifted > Y_MAX);
   assign sat_lo = (shifted < Y_MIN);

   always_comb begin
      y_clip = shifted[DATA_W-1:0];
      if (sat_hi) begin
         y_clip = OUT_MAX;
      end else if (sat_lo) begin
         y_clip = OUT_MIN;
      end
   end

`ifdef RELU_EN
   assign y_act = y_clip[DATA_W-1] ? '0 : y_clip;
`else
   assign y_act = y_clip;
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and registered-output targets
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      x_ready_next = 1'b0;
      y_valid_next = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = S_ACC;
            end
         end
         S_ACC: begin
            if (accept && last_beat) begin
               state_next = S_OUT;
            end
         end
         S_OUT: begin
            if (y_take) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      // Outputs are registered copies of the coming state so that x_ready
      // stays low through reset and rises on the first edge after it.
      x_ready_next = (state_next != S_OUT);
      y_valid_next = (state_next == S_OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_ready <= 1'b0;
         y_valid <= 1'b0;
      end else begin
         x_ready <= x_ready_next;
         y_valid <= y_valid_next;
      end
   end

   // ------------------------------------------------------------------
   // Accumulator, index and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         idx    <= '0;
         y_data <= '0;
         y_sat  <= 1'b0;
      end else begin
         if (accept) begin
            acc <= acc_next;
            if (last_beat) begin
               // idx parks at the last index while the result waits.
               y_data <= y_act;
               y_sat  <= sat_hi | sat_lo;
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end else if (y_take) begin
            acc <= '0;
            idx <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Weight register file; writes land on the next edge in any state
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++) begin
            w_mem[i] <= '0;
         end
      end else if (w_we && (int'(w_addr) < N_IN)) begin
         w_mem[w_addr] <= w_data;
      end
   end

endmodule

// File: tb/tb_neuron_mac_seq.sv
`timescale 1ns/1ps
// Directed bench for neuron_mac_seq (N_IN=8, DATA_W=32, FRAC_W=16).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_neuron_mac_seq;

   localparam int N_IN   = 8;
   localparam int DATA_W = 32;
   localparam int FRAC_W = 16;

   logic              clk;
   logic              rst;
   logic              w_we;
   logic [2:0]        w_addr;
   logic [DATA_W-1:0] w_data;
   logic [DATA_W-1:0] b;
   logic              x_valid;
   logic              x_ready;
   logic [DATA_W-1:0] x_data;
   logic              y_valid;
   logic              y_ready;
   logic [DATA_W-1:0] y_data;
   logic              y_sat;

   int checks = 0;
   int errors = 0;

   // Expected results: {y_sat, y_data}
   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W-1:0] vec [N_IN];

   neuron_mac_seq #(
      .N_IN   (N_IN),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .w_we    (w_we),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .b       (b),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .x_data  (x_data),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_data  (y_data),
      .y_sat   (y_sat)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic load_all(input logic [DATA_W-1:0] val);
      for (int i = 0; i < N_IN; i++) begin
         w_we   = 1'b1;
         w_addr = 3'(i);
         w_data = val;
         tick();
      end
      w_we = 1'b0;
   endtask

   task automatic load_one(input int addr, input logic [DATA_W-1:0] val);
      w_we   = 1'b1;
      w_addr = 3'(addr);
      w_data = val;
      tick();
      w_we   = 1'b0;
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] xv);
      logic ok;
      int   n;
      x_valid = 1'b1;
      x_data  = xv;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
         ok = x_ready;
         tick();
         n++;
      end
      if (!ok) chk("beat_timeout", 64'd0, 64'd1);
      x_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [DATA_W-1:0] bias);
      b = bias;
      for (int i = 0; i < N_IN; i++) begin
         send_beat(vec[i]);
      end
      chk("latency_y_valid", 64'(y_valid), 64'd1);
   endtask

   task automatic take_result(input string tag);
      logic [DATA_W:0] e;
      int              n;
      n = 0;
      while (!y_valid && n < 50) begin
         tick();
         n++;
      end
      if (!y_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
      e = exp_q.pop_front();
      chk({tag, "_data"}, 64'(y_data), 64'(e[DATA_W-1:0]));
      chk({tag, "_sat"},  64'(y_sat),  64'(e[DATA_W]));
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
      chk({tag, "_y_valid_drop"}, 64'(y_valid), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst     = 1'b1;
      w_we    = 1'b0;
      w_addr  = '0;
      w_data  = '0;
      b       = '0;
      x_valid = 1'b0;
      x_data  = '0;
      y_ready = 1'b0;
      tick();
      tick();
      chk("rst_x_ready", 64'(x_ready), 64'd0);
      chk("rst_y_valid", 64'(y_valid), 64'd0);
      chk("rst_y_data",  64'(y_data),  64'd0);
      chk("rst_y_sat",   64'(y_sat),   64'd0);
      rst = 1'b0;
      #1;
      chk("x_ready_before_edge", 64'(x_ready), 64'd0);
      tick();
      chk("x_ready_after_edge", 64'(x_ready), 64'd1);

      // Test 1: w=1.0, x=1..8 -> 36.0
      load_all(32'h0001_0000);
      for (int i = 0; i < N_IN; i++) vec[i] = 32'((i + 1) << 16);
      exp_q.push_back({1'b0, 32'h0024_0000});
      send_vec(32'h0);
      take_result("t1");

      // Test 2: bias -1.0 -> 35.0
      exp_q.push_back({1'b0, 32'h0023_0000});
      send_vec(32'hFFFF_0000);
      take_result("t2");

      // Test 3: positive and negative saturation
      load_all(32'h7FFF_FFFF);
      for (int i = 0; i < N_IN; i++) vec[i] = 32'h7FFF_FFFF;
      exp_q.push_back({1'b1, 32'h7FFF_FFFF});
      send_vec(32'h0);
      take_result("t3_pos");
      load_all(32'h8000_0001);
`ifdef RELU_EN
      exp_q.push_back({1'b1, 32'h0000_0000});
`else
      exp_q.push_back({1'b1, 32'h8000_0000});
`endif
      send_vec(32'h0);
      take_result("t3_neg");

      // Rounding boundaries: w[0]=1 lsb, others 0, single nonzero sample
      load_all(32'h0);
      load_one(0, 32'h0000_0001);
      for (int i = 0; i < N_IN; i++) vec[i] = 32'h0;
      vec[0] = 32'h0000_8000;          // exactly +0.5 lsb -> rounds up to 1
      exp_q.push_back({1'b0, 32'h0000_0001});
      send_vec(32'h0);
      take_result("rnd_half_pos");
      vec[0] = 32'hFFFF_8000;          // exactly -0.5 lsb -> rounds up to 0
      exp_q.push_back({1'b0, 32'h0000_0000});
      send_vec(32'h0);
      take_result("rnd_half_neg");
      vec[0] = 32'h0000_7FFF;          // just below half -> 0
      exp_q.push_back({1'b0, 32'h0000_0000});
      send_vec(32'h0);
      take_result("rnd_below_half");

      // Weight written in the same cycle it is read: old value is used
      load_all(32'h0001_0000);
      for (int i = 0; i < N_IN; i++) vec[i] = 32'h0001_0000;
      exp_q.push_back({1'b0, 32'h0008_0000});
      b       = 32'h0;
      w_we    = 1'b1;
      w_addr  = 3'd0;
      w_data  = 32'h0002_0000;
      send_beat(vec[0]);
      w_we    = 1'b0;
      for (int i = 1; i < N_IN; i++) send_beat(vec[i]);
      take_result("w_old_read");
      exp_q.push_back({1'b0, 32'h0009_0000});
      send_vec(32'h0);
      take_result("w_new_read");

      // Test 4: back-pressure on the result
      load_one(0, 32'h0001_0000);
      for (int i = 0; i < N_IN; i++) vec[i] = 32'((i + 1) << 16);
      exp_q.push_back({1'b0, 32'h0024_0000});
      send_vec(32'h0);
      x_valid = 1'b1;
      x_data  = 32'h0005_0000;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t4_x_ready_low", 64'(x_ready), 64'd0);
         chk("t4_y_valid_hold", 64'(y_valid), 64'd1);
         chk("t4_y_data_stable", 64'(y_data), 64'h0024_0000);
      end
      x_valid = 1'b0;
      take_result("t4");
      chk("t4_x_ready_back", 64'(x_ready), 64'd1);
      exp_q.push_back({1'b0, 32'h0024_0000});
      send_vec(32'h0);
      take_result("t4_next");

      // Test 5: reset in the middle of a vector
      b = 32'h0;
      for (int i = 0; i < 4; i++) send_beat(vec[i]);
      rst = 1'b1;
      #1;
      chk("t5_x_ready", 64'(x_ready), 64'd0);
      chk("t5_y_valid", 64'(y_valid), 64'd0);
      chk("t5_y_data",  64'(y_data),  64'd0);
      chk("t5_y_sat",   64'(y_sat),   64'd0);
      tick();
      rst = 1'b0;
      tick();
      exp_q.push_back({1'b0, 32'h0000_0000});   // weights cleared
      send_vec(32'h0);
      take_result("t5_zero_w");
      load_all(32'h0001_0000);
      exp_q.push_back({1'b0, 32'h0024_0000});
      send_vec(32'h0);
      take_result("t5_reload");

      // Test 6: x=-1.0, w=1.0 -> -8.0, or 0 through ReLU
      for (int i = 0; i < N_IN; i++) vec[i] = 32'hFFFF_0000;
`ifdef RELU_EN
      exp_q.push_back({1'b0, 32'h0000_0000});
`else
      exp_q.push_back({1'b0, 32'hFFF8_0000});
`endif
      send_vec(32'h0);
      take_result("t6");

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
